// File: rtl/wishbone_arbiter_if.sv
// Wishbone B4 pipelined bus bundle shared by the arbiter, its masters and the downstream slave.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_mosi,
    input  dat_miso, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_mosi,
    output dat_miso, ack, err, stall
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone B4 pipelined arbiter: one owner per bus cycle, with a
// watchdog that aborts the owner's cycle when the slave stops responding.
module wishbone_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  wishbone_interface.slave       masters [NUM_MASTERS],
  wishbone_interface.master      slave,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   timeout_event
);
  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int OUT_W  = $clog2(16) + 1;
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(16);
  localparam logic [WDOG_W-1:0] WDOG_FIRE = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W:0]    NM_EXT    = (IDX_W+1)'(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    ABORT
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    owner_reg, owner_next;
  logic [IDX_W-1:0]    last_reg, last_next;
  logic [OUT_W-1:0]    outstanding_reg, outstanding_next;
  logic [WDOG_W-1:0]   wdog_reg, wdog_next;
  logic                abort_first_reg, abort_first_next;

  // Flattened view of the upstream request side
  logic                m_cyc      [NUM_MASTERS];
  logic                m_stb      [NUM_MASTERS];
  logic                m_we       [NUM_MASTERS];
  logic [31:0]         m_adr      [NUM_MASTERS];
  logic [3:0]          m_sel      [NUM_MASTERS];
  logic [31:0]         m_dat_mosi [NUM_MASTERS];

  logic                s_ack;
  logic                s_err;
  logic                s_stall;
  logic [31:0]         s_dat_miso;

  logic                owner_cyc;
  logic                accepted;
  logic                resp;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W:0]      cand;

  assign s_ack      = slave.ack;
  assign s_err      = slave.err;
  assign s_stall    = slave.stall;
  assign s_dat_miso = slave.dat_miso;

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      logic owner_fwd;
      logic owner_abort;

      assign owner_fwd   = (state_reg == GRANTED) && (owner_reg == IDX_W'(gi));
      assign owner_abort = (state_reg == ABORT) && (owner_reg == IDX_W'(gi));

      assign m_cyc[gi]      = masters[gi].cyc;
      assign m_stb[gi]      = masters[gi].stb;
      assign m_we[gi]       = masters[gi].we;
      assign m_adr[gi]      = masters[gi].adr;
      assign m_sel[gi]      = masters[gi].sel;
      assign m_dat_mosi[gi] = masters[gi].dat_mosi;

      // Only the forwarding owner sees the slave; the abort error is a single-cycle pulse
      assign masters[gi].ack      = owner_fwd & s_ack;
      assign masters[gi].err      = (owner_fwd & s_err) | (owner_abort & abort_first_reg);
      assign masters[gi].stall    = owner_fwd ? s_stall : 1'b1;
      assign masters[gi].dat_miso = owner_fwd ? s_dat_miso : 32'h0;
    end
  endgenerate

  assign owner_cyc = m_cyc[owner_reg];

  // Address/data path always follows the owner; only cyc/stb are gated
  assign slave.cyc      = (state_reg == GRANTED) & owner_cyc;
  assign slave.stb      = (state_reg == GRANTED) & m_stb[owner_reg];
  assign slave.we       = m_we[owner_reg];
  assign slave.adr      = m_adr[owner_reg];
  assign slave.sel      = m_sel[owner_reg];
  assign slave.dat_mosi = m_dat_mosi[owner_reg];

  assign accepted = m_stb[owner_reg] & ~s_stall;
  assign resp     = s_ack | s_err;

  always_comb begin
    grant = '0;
    if (state_reg != IDLE) begin
      grant[owner_reg] = 1'b1;
    end
  end

  // Scan from farthest to nearest so the first requester after last_reg wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = {1'b0, last_reg} + (IDX_W+1)'(k);
      if (cand >= NM_EXT) begin
        cand = cand - NM_EXT;
      end
      if (m_cyc[cand[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_next        = last_reg;
    outstanding_next = outstanding_reg;
    wdog_next        = wdog_reg;
    abort_first_next = 1'b0;
    timeout_event    = 1'b0;

    case (state_reg)
      IDLE: begin
        outstanding_next = '0;
        wdog_next        = '0;
        if (pick_valid) begin
          owner_next = pick_idx;
          state_next = GRANTED;
        end
      end

      GRANTED: begin
        if (!owner_cyc) begin
          // Responses still in flight belong to a finished cycle; forget them
          last_next        = owner_reg;
          state_next       = IDLE;
          outstanding_next = '0;
          wdog_next        = '0;
        end else begin
          if (accepted && !resp && (outstanding_reg != OUT_MAX)) begin
            outstanding_next = outstanding_reg + 1'b1;
          end else if (resp && !accepted && (outstanding_reg != '0)) begin
            outstanding_next = outstanding_reg - 1'b1;
          end

          if (resp || (outstanding_reg == '0)) begin
            wdog_next = '0;
          end else begin
            wdog_next = wdog_reg + 1'b1;
          end

          // A response in the firing cycle cancels the abort
          if (!resp && (outstanding_reg != '0) && (wdog_reg == WDOG_FIRE)) begin
            state_next       = ABORT;
            timeout_event    = 1'b1;
            outstanding_next = '0;
            wdog_next        = '0;
            abort_first_next = 1'b1;
          end
        end
      end

      ABORT: begin
        outstanding_next = '0;
        wdog_next        = '0;
        if (!owner_cyc) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      owner_reg       <= '0;
      last_reg        <= IDX_W'(NUM_MASTERS - 1);
      outstanding_reg <= '0;
      wdog_reg        <= '0;
      abort_first_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_reg        <= last_next;
      outstanding_reg <= outstanding_next;
      wdog_reg        <= wdog_next;
      abort_first_reg <= abort_first_next;
    end
  end
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Scoreboard bench for wishbone_arbiter: two masters, a simple slave model, watchdog of 16 cycles.
module tb_wishbone_arbiter;
  localparam int NM = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wishbone_interface m_if [NM] ();
  wishbone_interface s_if ();

  logic [NM-1:0] grant;
  logic          timeout_event;

  wishbone_arbiter #(
    .NUM_MASTERS   (NM),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .masters      (m_if),
    .slave        (s_if),
    .grant        (grant),
    .timeout_event(timeout_event)
  );

  // Master-side drive and observation
  logic [NM-1:0] m_cyc = '0;
  logic [NM-1:0] m_stb = '0;
  logic [NM-1:0] m_we  = '0;
  logic [31:0]   m_adr [NM];
  logic [31:0]   m_dat [NM];
  wire  [NM-1:0] m_ack;
  wire  [NM-1:0] m_err;
  wire  [NM-1:0] m_stall;
  wire  [31:0]   m_dmiso [NM];

  generate
    for (genvar gi = 0; gi < NM; gi++) begin : g_m
      assign m_if[gi].cyc      = m_cyc[gi];
      assign m_if[gi].stb      = m_stb[gi];
      assign m_if[gi].we       = m_we[gi];
      assign m_if[gi].adr      = m_adr[gi];
      assign m_if[gi].sel      = 4'hF;
      assign m_if[gi].dat_mosi = m_dat[gi];
      assign m_ack[gi]         = m_if[gi].ack;
      assign m_err[gi]         = m_if[gi].err;
      assign m_stall[gi]       = m_if[gi].stall;
      assign m_dmiso[gi]       = m_if[gi].dat_miso;
    end
  endgenerate

  // Slave model: optional ack one cycle after acceptance, read data = DEAD:adr[15:0]
  logic        auto_ack  = 1'b1;
  logic        force_ack = 1'b0;
  logic        ack_r     = 1'b0;
  logic [31:0] dat_r     = '0;
  logic [31:0] force_dat = '0;

  assign s_if.ack      = ack_r | force_ack;
  assign s_if.err      = 1'b0;
  assign s_if.stall    = 1'b0;
  assign s_if.dat_miso = force_ack ? force_dat : dat_r;

  always @(posedge clk) begin
    ack_r <= auto_ack & s_if.cyc & s_if.stb & ~s_if.stall;
    dat_r <= {16'hDEAD, s_if.adr[15:0]};
  end

  typedef struct {
    int          mst;
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   vectors     = 0;
  int   miscompares = 0;

  // Monitor: every ack/err delivered to a master must match the head of the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (m_ack[i] || m_err[i]) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_resp: master %0d ack=%b err=%b dat=%h, required no response",
                   i, m_ack[i], m_err[i], m_dmiso[i]);
        end else begin
          e_mon = sb.pop_front();
          if ((e_mon.mst != i) || (m_err[i] !== e_mon.err) || (m_ack[i] !== !e_mon.err) ||
              (e_mon.chk && (m_dmiso[i] !== e_mon.dat))) begin
            miscompares++;
            $display("FAIL resp: got master %0d ack=%b err=%b dat=%h, required master %0d err=%b dat=%h",
                     i, m_ack[i], m_err[i], m_dmiso[i], e_mon.mst, e_mon.err, e_mon.dat);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push(input int mst, input logic err, input logic chk, input logic [31:0] dat);
    exp_t e;
    e.mst = mst;
    e.err = err;
    e.chk = chk;
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Advance until some grant appears (bounded); caller compares the result
  task automatic wait_grant();
    int n;
    n = 0;
    while ((grant == '0) && (n < 8)) begin
      next_cycle();
      sample();
      n++;
    end
  endtask

  logic [31:0] t1_adr [4] = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
  logic [31:0] t1_dat [4] = '{32'hDEAD_0100, 32'hDEAD_0104, 32'hDEAD_0108, 32'hDEAD_010C};
  logic [31:0] fair_dat [8] = '{32'hDEAD_0400, 32'hDEAD_0404, 32'hDEAD_0408, 32'hDEAD_040C,
                                32'hDEAD_0410, 32'hDEAD_0414, 32'hDEAD_0418, 32'hDEAD_041C};

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    int w;
    logic seen;
    for (int i = 0; i < NM; i++) begin
      m_adr[i] = '0;
      m_dat[i] = '0;
    end

    // Reset state
    next_cycle();
    next_cycle();
    sample();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_timeout", 32'(timeout_event), 32'h0);
    check("rst_stall", 32'(m_stall), 32'h3);
    check("rst_ack_err", 32'({m_ack, m_err}), 32'h0);
    check("rst_slave_cyc_stb", 32'({s_if.cyc, s_if.stb}), 32'h0);

    // Single master, 4 pipelined reads
    next_cycle();
    rst = 1'b0;
    m_cyc[0] = 1'b1;
    sample();
    check("t1_grant_req_cycle", 32'(grant), 32'h0);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      m_stb[0] = 1'b1;
      m_adr[0] = t1_adr[b];
      push(0, 1'b0, 1'b1, t1_dat[b]);
      sample();
      if (b == 0) begin
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_stall0", 32'(m_stall[0]), 32'h0);
        check("t1_slave_cyc", 32'(s_if.cyc), 32'h1);
      end
    end
    next_cycle();
    m_stb[0] = 1'b0;
    sample();
    next_cycle();
    m_cyc[0] = 1'b0;
    sample();
    check("t1_grant_at_drop", 32'(grant), 32'h1);
    next_cycle();
    sample();
    check("t1_grant_released", 32'(grant), 32'h0);

    // Contention from reset
    next_cycle();
    rst = 1'b1;
    sample();
    next_cycle();
    rst = 1'b0;
    m_cyc = 2'b11;
    sample();
    check("t2_grant_req_cycle", 32'(grant), 32'h0);
    next_cycle();
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h0000_0200;
    push(0, 1'b0, 1'b1, 32'hDEAD_0200);
    sample();
    check("t2_grant_m0", 32'(grant), 32'h1);
    check("t2_stall_m1", 32'(m_stall[1]), 32'h1);
    check("t2_stall_m0", 32'(m_stall[0]), 32'h0);
    next_cycle();
    m_stb[0] = 1'b0;
    sample();
    next_cycle();
    m_cyc[0] = 1'b0;
    sample();
    check("t2_grant_at_drop", 32'(grant), 32'h1);
    next_cycle();
    sample();
    check("t2_dead_cycle", 32'(grant), 32'h0);
    check("t2_stall_m1_dead", 32'(m_stall[1]), 32'h1);
    next_cycle();
    m_stb[1] = 1'b1;
    m_adr[1] = 32'h0000_0300;
    push(1, 1'b0, 1'b1, 32'hDEAD_0300);
    sample();
    check("t2_grant_m1", 32'(grant), 32'h2);
    check("t2_stall_m1_owner", 32'(m_stall[1]), 32'h0);
    next_cycle();
    m_stb[1] = 1'b0;
    sample();
    next_cycle();
    m_cyc[1] = 1'b0;
    sample();
    next_cycle();
    sample();

    // Fairness: both request continuously, one beat per ownership
    for (int k = 0; k < 8; k++) begin
      w = k % 2;
      next_cycle();
      m_cyc = 2'b11;
      sample();
      wait_grant();
      check($sformatf("t3_fair_grant_%0d", k), 32'(grant), (w == 0) ? 32'h1 : 32'h2);
      next_cycle();
      m_stb[w] = 1'b1;
      m_adr[w] = 32'h0000_0400 + 32'(4 * k);
      push(w, 1'b0, 1'b1, fair_dat[k]);
      sample();
      next_cycle();
      m_stb[w] = 1'b0;
      sample();
      next_cycle();
      m_cyc[w] = 1'b0;
      sample();
    end
    next_cycle();
    m_cyc = 2'b00;
    sample();
    next_cycle();
    sample();

    // Watchdog: one write never acknowledged
    next_cycle();
    auto_ack = 1'b0;
    m_cyc[0] = 1'b1;
    sample();
    wait_grant();
    check("t4_grant", 32'(grant), 32'h1);
    next_cycle();
    m_stb[0] = 1'b1;
    m_we[0]  = 1'b1;
    m_adr[0] = 32'h0000_0500;
    push(0, 1'b1, 1'b0, 32'h0);
    sample();
    check("t4_accept", 32'(m_stall[0]), 32'h0);
    seen = 1'b0;
    for (int j = 1; j < TO; j++) begin
      next_cycle();
      m_stb[0] = 1'b0;
      sample();
      seen = seen | timeout_event | m_err[0];
    end
    check("t4_no_early_timeout", 32'(seen), 32'h0);
    next_cycle();
    sample();
    check("t4_timeout_event", 32'(timeout_event), 32'h1);
    check("t4_cyc_before_abort", 32'(s_if.cyc), 32'h1);
    next_cycle();
    sample();
    check("t4_abort_err", 32'(m_err[0]), 32'h1);
    check("t4_abort_slave_cyc", 32'(s_if.cyc), 32'h0);
    check("t4_timeout_single", 32'(timeout_event), 32'h0);
    check("t4_abort_stall", 32'(m_stall[0]), 32'h1);
    next_cycle();
    sample();
    check("t4_err_single", 32'(m_err[0]), 32'h0);
    check("t4_abort_slave_cyc2", 32'(s_if.cyc), 32'h0);
    check("t4_abort_grant", 32'(grant), 32'h1);
    next_cycle();
    m_cyc[0] = 1'b0;
    m_we[0]  = 1'b0;
    sample();
    next_cycle();
    sample();
    check("t4_idle_after_drop", 32'(grant), 32'h0);

    // Ack arriving in the firing cycle wins over the watchdog
    next_cycle();
    m_cyc[0] = 1'b1;
    sample();
    wait_grant();
    check("t5_grant", 32'(grant), 32'h1);
    next_cycle();
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h0000_0600;
    push(0, 1'b0, 1'b1, 32'hCAFE_0600);
    sample();
    for (int j = 1; j < TO; j++) begin
      next_cycle();
      m_stb[0] = 1'b0;
      sample();
    end
    next_cycle();
    force_ack = 1'b1;
    force_dat = 32'hCAFE_0600;
    sample();
    check("t5_no_timeout", 32'(timeout_event), 32'h0);
    next_cycle();
    force_ack = 1'b0;
    sample();
    check("t5_no_err", 32'(m_err[0]), 32'h0);
    check("t5_still_cyc", 32'(s_if.cyc), 32'h1);
    check("t5_still_granted", 32'(grant), 32'h1);
    next_cycle();
    auto_ack = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h0000_0604;
    push(0, 1'b0, 1'b1, 32'hDEAD_0604);
    sample();
    next_cycle();
    m_stb[0] = 1'b0;
    sample();
    next_cycle();
    m_cyc[0] = 1'b0;
    sample();
    next_cycle();
    sample();
    check("t5_released", 32'(grant), 32'h0);

    // Reset with three outstanding requests
    next_cycle();
    auto_ack = 1'b0;
    m_cyc[0] = 1'b1;
    sample();
    wait_grant();
    check("t6_grant", 32'(grant), 32'h1);
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      m_stb[0] = 1'b1;
      m_adr[0] = 32'h0000_0700 + 32'(4 * b);
      sample();
    end
    next_cycle();
    m_stb[0] = 1'b0;
    rst = 1'b1;
    sample();
    next_cycle();
    rst = 1'b0;
    m_cyc[0] = 1'b0;
    force_ack = 1'b1;
    force_dat = 32'h0BAD_0700;
    sample();
    check("t6_grant_after_rst", 32'(grant), 32'h0);
    check("t6_slave_cyc_after_rst", 32'(s_if.cyc), 32'h0);
    check("t6_no_ack_fwd", 32'(m_ack), 32'h0);
    next_cycle();
    force_ack = 1'b0;
    sample();
    next_cycle();
    force_ack = 1'b1;
    sample();
    check("t6_late_ack_dropped", 32'(m_ack), 32'h0);
    next_cycle();
    force_ack = 1'b0;
    sample();

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

Round-robin Wishbone (B4 pipelined) arbiter that shares one downstream bus among `NUM_MASTERS` upstream masters, e.g. the CPU data port and a DMA engine in front of `wishbone_interconnect`. Grants are held for a full bus cycle: from the rise to the fall of the granted master's `cyc`. A per-grant watchdog aborts transactions the slave never acknowledges, so a hung peripheral cannot lock the bus.

## Interface
- `NUM_MASTERS`, default 2: number of upstream masters, 2..8.
- `TIMEOUT_CYCLES`, default 1024: cycles without `ack`/`err` while requests are outstanding before the arbiter aborts; ≥ 2.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `masters` `wishbone_interface.slave` [NUM_MASTERS]: upstream ports with `cyc`, `stb`, `we`, `adr[31:0]`, `sel[3:0]`, `dat_mosi[31:0]`, `dat_miso[31:0]`, `ack`, `err`, `stall`.
- `slave` `wishbone_interface.master` 1: downstream port with the same signal set.
- `grant` output NUM_MASTERS: one-hot current owner; all-zero when idle.
- `timeout_event` output 1: one-cycle pulse when a watchdog abort fires.

## Operation
- States: IDLE, GRANTED, ABORT.
- Registered state:
  - `owner` index.
  - `last` index.
  - `outstanding` counter, `$clog2(NUM_MASTERS*0+16)+1` = 5 bits, saturating at 16.
  - `wdog` counter, `$clog2(TIMEOUT_CYCLES)` bits.
- IDLE:
  - `slave.cyc`/`slave.stb` = 0.
  - All masters see `stall`=1, `ack`=0, `err`=0.
  - If any `masters[i].cyc` = 1, pick the first requester searching `last+1, last+2, …` modulo NUM_MASTERS. Set `owner` to it, go to GRANTED.
- GRANTED:
  - `slave` carries `masters[owner]`'s `cyc`, `stb`, `we`, `adr`, `sel`, `dat_mosi`.
  - `masters[owner]` receives `slave`'s `dat_miso`, `ack`, `err`, `stall`.
  - Non-owners see `stall`=1, `ack`=0, `err`=0, `dat_miso`=0.
- Outstanding tracking, in GRANTED:
  - `outstanding` +1 on `stb & !stall`.
  - `outstanding` −1 on `ack | err`.
  - Both in the same cycle leave it unchanged.
- Release: `masters[owner].cyc`=0 in GRANTED → `last`←`owner`, go to IDLE. A response arriving after release is dropped.
- Watchdog:
  - `wdog` clears on `ack | err`, or when `outstanding`=0.
  - Otherwise it increments.
  - When `wdog`=TIMEOUT_CYCLES−1 with `outstanding`>0: go to ABORT and pulse `timeout_event`.
- ABORT:
  - `slave.cyc`=0.
  - `masters[owner].err`=1 for the first ABORT cycle only; `stall`=1 throughout.
  - `outstanding` clears.
  - Stay in ABORT until `masters[owner].cyc`=0, then `last`←`owner` and go to IDLE.
- Data and `adr` into the slave are don't-care when `slave.cyc`=0, but are driven from `masters[owner]` to avoid extra muxing.

## Timing
- Reset values:
  - State IDLE.
  - `owner`=0, `last`=NUM_MASTERS−1, so master 0 wins the first contention.
  - `outstanding`=0, `wdog`=0.
  - `grant`=0, `timeout_event`=0.
  - `slave.cyc`=`slave.stb`=0.
  - All master `stall`=1, `ack`=0, `err`=0.
- Arbitration latency: the request is seen in cycle N; the grant and first forwarding happen in cycle N+1. The first `stb` can be accepted in N+1.
- Forwarding in GRANTED is purely combinational both ways; no added latency per beat.
- Release to re-grant:
  - `cyc` falls in cycle N; IDLE in N+1; the next owner is granted in N+2.
  - There is always one dead cycle between owners, even if a master re-requests immediately.
- Simultaneous requests in IDLE: exactly one grant, per the round-robin order. Losers keep `stall`=1 and must hold their request.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last `ack`/`err`, or after `outstanding` became nonzero.
- An `ack` in the same cycle the watchdog would fire cancels the abort; `ack` wins.
- `rst` asserted mid-transaction: the next cycle is IDLE with all reset values. No `ack`/`err` is forwarded in that cycle.

## Test plan
- Single master: master 0 issues 4 pipelined reads with a slave `ack` latency of 1. Expect:
  - `grant`=01 one cycle after `cyc`.
  - 4 `ack`s with the correct `dat_miso`.
  - `grant`=00 one cycle after `cyc` falls.
- Contention from reset: masters 0 and 1 raise `cyc` in the same cycle. Expect:
  - Master 0 is granted.
  - Master 1 sees `stall`=1 and gets the grant exactly 2 cycles after master 0 drops `cyc`.
- Fairness: both masters request continuously, 1 beat each, for 8 cycles of ownership. Expect `grant` alternating 01,10,01,10…, with no master granted twice in a row.
- Watchdog: TIMEOUT_CYCLES=16, the slave never acks one write. Expect:
  - `timeout_event` plus a single-cycle `err` to the owner 16 cycles after acceptance.
  - `slave.cyc`=0 during ABORT.
  - IDLE after the master drops `cyc`.
- Ack/timeout collision: `ack` arrives in exactly the firing cycle. Expect no `err`, no `timeout_event`, and the transaction to complete normally.
- Reset mid-burst: assert `rst` with 3 outstanding. Expect the next cycle to show `grant`=0, `slave.cyc`=0, and a later `ack` from the slave not forwarded to any master.
